// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU
module div_sequencer #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  input  logic             Start,
  input  logic [1:0]       DivOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] DivOut
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_rem_q, is_rem_d;
  logic [WIDTH-1:0] op1_q, op1_d;      // raw dividend, kept for the divide-by-zero remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;      // |dividend| shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;      // |divisor|
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
  logic             neg_q_q, neg_q_d;  // negate quotient at FIX
  logic             neg_r_q, neg_r_d;  // negate remainder at FIX
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand decode for the op being offered in IDLE
  logic             in_signed, in_rem, sign1, sign2, in_div0, in_ovf;
  logic [WIDTH-1:0] abs1, abs2;
  assign in_signed = ~DivOp[0];
  assign in_rem    = DivOp[1];
  assign sign1     = in_signed & Operand1[WIDTH-1];
  assign sign2     = in_signed & Operand2[WIDTH-1];
  assign abs1      = sign1 ? -Operand1 : Operand1;
  assign abs2      = sign2 ? -Operand2 : Operand2;
  assign in_div0   = (Operand2 == '0);
  assign in_ovf    = in_signed & (Operand1 == MIN_NEG) & (Operand2 == '1);

  // One restoring step; bit WIDTH of the difference acts as the borrow
  logic [WIDTH:0]   rem_shift, diff;
  logic             ge;
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign ge        = ~diff[WIDTH];

  function automatic logic [WIDTH-1:0] special_res(input logic is_rem, input logic div0,
                                                    input logic [WIDTH-1:0] dividend);
    if (div0) return is_rem ? dividend : '1;
    return is_rem ? '0 : MIN_NEG;
  endfunction

  // Sign correction and special-case override applied in FIX
  logic [WIDTH-1:0] q_fix, r_fix, fix_res;
  assign q_fix   = neg_q_q ? -dvd_q : dvd_q;
  assign r_fix   = neg_r_q ? -rem_q : rem_q;
  assign fix_res = (div0_q | ovf_q) ? special_res(is_rem_q, div0_q, op1_q)
                                    : (is_rem_q ? r_fix : q_fix);

  // Next-state, datapath updates and registered output decode
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_rem_d = is_rem_q;
    op1_d    = op1_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    out_d    = out_q;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            is_rem_d = in_rem;
            op1_d    = Operand1;
            dvd_d    = abs1;
            dvs_d    = abs2;
            rem_d    = '0;
            neg_q_d  = sign1 ^ sign2;
            neg_r_d  = sign1;
            div0_d   = in_div0;
            ovf_d    = in_ovf;
            count_d  = '0;
            if (ZERO_FAST && (in_div0 || in_ovf)) begin
              out_d   = special_res(in_rem, in_div0, Operand1);
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          dvd_d   = {dvd_q[WIDTH-2:0], ge};
          rem_d   = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = FIX;
        end
        FIX: begin
          out_d   = fix_res;
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q  <= IDLE;
      count_q  <= '0;
      is_rem_q <= 1'b0;
      op1_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_rem_q <= is_rem_d;
      op1_q    <= op1_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign DivOut = out_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer (fast and full special-case paths)
module tb_div_sequencer;

  logic        clk;
  logic        rst_n;
  // fast-path instance (ZERO_FAST=1)
  logic        z_start, z_flush, z_busy, z_done;
  logic [1:0]  z_op;
  logic [31:0] z_a, z_b, z_out;
  // full-iteration instance (ZERO_FAST=0)
  logic        s_start, s_flush, s_busy, s_done;
  logic [1:0]  s_op;
  logic [31:0] s_a, s_b, s_out;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_sequencer #(.WIDTH(32), .ZERO_FAST(1'b1)) dut (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .Start(z_start), .DivOp(z_op),
    .Operand1(z_a), .Operand2(z_b), .Flush(z_flush),
    .Busy(z_busy), .Done(z_done), .DivOut(z_out)
  );

  div_sequencer #(.WIDTH(32), .ZERO_FAST(1'b0)) dut_slow (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .Start(s_start), .DivOp(s_op),
    .Operand1(s_a), .Operand2(s_b), .Flush(s_flush),
    .Busy(s_busy), .Done(s_done), .DivOut(s_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer an op to the chosen instance and follow it to Done.
  // exp_lat counts edges from the first edge after the inputs are set.
  task automatic run_op(input string tag, input bit slow, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input int exp_lat,
                        input int exp_busy, input bit keep);
    int n, busy_n;
    logic dn;
    if (slow) begin s_start = 1'b1; s_op = op; s_a = a; s_b = b; end
    else      begin z_start = 1'b1; z_op = op; z_a = a; z_b = b; end
    n = 0; busy_n = 0; dn = 1'b0;
    while (!dn && n < 60) begin
      step();
      n++;
      if (slow ? s_busy : z_busy) busy_n++;
      dn = slow ? s_done : z_done;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_n), 32'(exp_busy));
    check({tag, "_out"}, slow ? s_out : z_out, exp_out);
    if (!keep) begin
      if (slow) s_start = 1'b0; else z_start = 1'b0;
      step();
      check({tag, "_pulse"}, {31'b0, slow ? s_done : z_done}, 32'd0);
      check({tag, "_hold"}, slow ? s_out : z_out, exp_out);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    z_start = 1'b0; z_flush = 1'b0; z_op = 2'b00; z_a = '0; z_b = '0;
    s_start = 1'b0; s_flush = 1'b0; s_op = 2'b00; s_a = '0; s_b = '0;
    #12;
    check("rst_busy", {31'b0, z_busy}, 32'd0);
    check("rst_done", {31'b0, z_done}, 32'd0);
    check("rst_out", z_out, 32'd0);
    check("rst_out_slow", s_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: unsigned
    run_op("divu_100_7", 1'b0, OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 33, 1'b0);
    run_op("remu_100_7", 1'b0, OP_REMU, 32'd100, 32'd7, 32'd2, 34, 33, 1'b0);
    // 2: signed
    run_op("div_m7_2", 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 33, 1'b0);
    run_op("rem_m7_2", 1'b0, OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33, 1'b0);
    run_op("div_7_m2", 1'b0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 33, 1'b0);
    run_op("rem_7_m2", 1'b0, OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 33, 1'b0);
    // 3: divide by zero, fast and full paths
    run_op("divu_5_0", 1'b0, OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
    run_op("remu_5_0", 1'b0, OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0);
    run_op("s_divu_5_0", 1'b1, OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 34, 33, 1'b0);
    run_op("s_remu_5_0", 1'b1, OP_REMU, 32'd5, 32'd0, 32'd5, 34, 33, 1'b0);
    run_op("s_div_m7_0", 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 34, 33, 1'b0);
    run_op("s_rem_m7_0", 1'b1, OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 34, 33, 1'b0);
    // 4: signed overflow
    run_op("div_ovf", 1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
    run_op("rem_ovf", 1'b0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0);
    run_op("s_div_ovf", 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 33, 1'b0);
    run_op("s_rem_ovf", 1'b1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 33, 1'b0);

    // 5: flush mid-calculation; DivOut holds 0 from rem_ovf
    z_start = 1'b1; z_op = OP_DIVU; z_a = 32'd50; z_b = 32'd5;
    for (int i = 0; i < 10; i++) step();
    check("fl_busy_before", {31'b0, z_busy}, 32'd1);
    z_flush = 1'b1; z_start = 1'b0;
    step();
    z_flush = 1'b0;
    check("fl_busy", {31'b0, z_busy}, 32'd0);
    check("fl_done", {31'b0, z_done}, 32'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (z_done) seen_done++;
      end
      check("fl_no_done", 32'(seen_done), 32'd0);
    end
    check("fl_out_kept", z_out, 32'd0);
    run_op("divu_9_3", 1'b0, OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 33, 1'b0);

    // 6: asynchronous reset mid-operation
    z_start = 1'b1; z_op = OP_DIVU; z_a = 32'd1000; z_b = 32'd10;
    for (int i = 0; i < 20; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", {31'b0, z_busy}, 32'd0);
    check("ar_done", {31'b0, z_done}, 32'd0);
    check("ar_out", z_out, 32'd0);
    z_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("b2b_divu", 1'b0, OP_DIVU, 32'd10, 32'd3, 32'd3, 34, 33, 1'b1);
    run_op("b2b_remu", 1'b0, OP_REMU, 32'd10, 32'd3, 32'd1, 35, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
